// File: rtl/exp_arbiter.sv
// Four-lane round-robin arbiter in front of a shared exponential unit (level req/ack handshake).
// Optional build macro EXP_ARB_TIMEOUT_EN: abort a RUN that sees no ExpAck for TIMEOUT cycles and flag Err.
module exp_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [3:0]      Req,
  input  logic [4*DW-1:0] ReqData,
  output logic [3:0]      Done,
  output logic [DW-1:0]   Result,
  output logic [1:0]      ResultId,
  output logic            Err,
  output logic            Busy,
  output logic            ExpStr,
  output logic [DW-1:0]   ExpData,
  input  logic            ExpAck,
  input  logic [DW-1:0]   ExpDataOut
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  // Returns {found, lane}: the first requesting lane at or after ptr, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] sel;
    logic [1:0] lane;
    sel = '0;
    for (int k = 3; k >= 0; k--) begin
      lane = ptr + 2'(k);
      if (req[lane]) sel = {1'b1, lane};
    end
    return sel;
  endfunction

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [3:0]    done_q, done_d;
  logic [DW-1:0] result_q, result_d;
  logic [1:0]    result_id_q, result_id_d;
  logic          busy_q, busy_d;
  logic          exp_str_q, exp_str_d;
  logic [DW-1:0] exp_data_q, exp_data_d;
  logic [2:0]    pick;

`ifdef EXP_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic          unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  assign pick = rr_pick(Req, ptr_q);

  always_comb begin
    // NOTE: every *_d gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    result_d    = result_q;
    result_id_d = result_id_q;
    exp_str_d   = exp_str_q;
    exp_data_d  = exp_data_q;
`ifdef EXP_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pick[2]) begin
          gnt_d      = pick[1:0];
          ptr_d      = pick[1:0] + 2'd1;
          exp_data_d = ReqData[int'(pick[1:0])*DW +: DW];
          exp_str_d  = 1'b1;
          state_d    = S_RUN;
`ifdef EXP_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_RUN: begin
        // Req is deliberately not looked at here; the grant is frozen until RELEASE ends.
        if (ExpAck) begin
          result_d    = ExpDataOut;
          result_id_d = gnt_q;
          exp_str_d   = 1'b0;
          done_d      = 4'b0001 << gnt_q;
          state_d     = S_DONE;
        end
`ifdef EXP_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_d    = '0;
          result_id_d = gnt_q;
          exp_str_d   = 1'b0;
          done_d      = 4'b0001 << gnt_q;
          err_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the unit to drop its ack so the next ExpStr is seen as a fresh request.
        if (!ExpAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      result_q    <= '0;
      result_id_q <= '0;
      busy_q      <= 1'b0;
      exp_str_q   <= 1'b0;
      exp_data_q  <= '0;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
      busy_q      <= busy_d;
      exp_str_q   <= exp_str_d;
      exp_data_q  <= exp_data_d;
`ifdef EXP_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign Done     = done_q;
  assign Result   = result_q;
  assign ResultId = result_id_q;
  assign Busy     = busy_q;
  assign ExpStr   = exp_str_q;
  assign ExpData  = exp_data_q;
`ifdef EXP_ARB_TIMEOUT_EN
  assign Err      = err_q;
`else
  assign Err      = 1'b0;
`endif

endmodule

// File: doc/exp_arbiter.md
EXP_ARBITER -- requirements
Module: exp_arbiter

Interface
REQ-001 SHALL have parameter: DW, 32, data width of operands and results.
REQ-002 SHALL have parameter: TIMEOUT, 255, WAIT-state cycle limit (used only with EXP_ARB_TIMEOUT_EN).
REQ-003 SHALL have port: Clock  input  1  rising-edge clock.
REQ-004 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: Req  input  4  per-lane request level; lane i holds Req[i] high until Done[i].
REQ-006 SHALL have port: ReqData  input  4*DW  lane i operand at bits [i*DW +: DW]; stable while Req[i] high.
REQ-007 SHALL have port: Done  output  4  one-hot, one-cycle completion pulse.
REQ-008 SHALL have port: Result  output  DW  exp result, valid when any Done bit is high.
REQ-009 SHALL have port: ResultId  output  2  lane index of Result.
REQ-010 SHALL have port: Err  output  1  high with Done when the operation timed out.
REQ-011 SHALL have port: Busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: ExpStr  output  1  level-enable to the shared exponential unit.
REQ-013 SHALL have port: ExpData  output  DW  operand to the exponential unit.
REQ-014 SHALL have port: ExpAck  input  1  level acknowledge from the exponential unit.
REQ-015 SHALL have port: ExpDataOut  input  DW  exponential unit result.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE, RELEASE; all outputs registered.
REQ-017 IDLE: if any Req bit high, SHALL grant by round-robin starting at pointer Ptr, latch lane index Gnt, load ExpData from that lane's ReqData, set ExpStr=1, and go to RUN on the next edge.
REQ-018 Round-robin: search order Ptr, Ptr+1, ... mod 4; on grant, SHALL set Ptr = Gnt+1 mod 4 (3 wraps to 0).
REQ-019 RUN: ExpStr and ExpData SHALL be held constant; Req changes SHALL be ignored.
REQ-020 RUN: on first sampled ExpAck=1, SHALL capture ExpDataOut into Result, set ResultId=Gnt, drive ExpStr=0, and go to DONE.
REQ-021 DONE: Done[Gnt] SHALL be high for exactly this one cycle; next state is RELEASE.
REQ-022 RELEASE: ExpStr SHALL be 0; SHALL remain in RELEASE while ExpAck=1 and go to IDLE on the first cycle ExpAck=0, so that ExpStr is low for at least 2 cycles between operations.
REQ-023 Result and ResultId SHALL hold their values until the next capture; Done SHALL be 0 outside DONE.
REQ-024 A lane whose Req stays high after Done SHALL be re-served only after all other requesting lanes, per round-robin.
REQ-025 Best-case latency: Req sampled in IDLE at edge t, then ExpStr=1 after t, Done after edge (first ExpAck edge + 1).

Reset
REQ-026 While Reset=0, SHALL force state IDLE and Ptr=0, and drive Done=0, Result=0, ResultId=0, Err=0, Busy=0, ExpStr=0, ExpData=0, asynchronously.
REQ-027 Reset asserted in any state SHALL abort the operation without a Done pulse; the lane being served SHALL be re-arbitrated normally after release.

Configuration
REQ-028 With EXP_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to RUN and increment each RUN cycle; when it reaches TIMEOUT with ExpAck=0, SHALL set Result=0 and Err=1 and go to DONE (Done[Gnt] pulses), then RELEASE.
REQ-029 With EXP_ARB_TIMEOUT_EN defined, Err SHALL be 0 on every non-timeout completion.
REQ-030 Without EXP_ARB_TIMEOUT_EN: no counter; Err SHALL be tied 0; RUN SHALL wait indefinitely for ExpAck.

Verification
REQ-031 Req=0100, ReqData lane2=0x00000000, model returns 0x3f800000 after 141 cycles. Required: ExpData=0x00000000 during RUN, then Done=0100, Result=0x3f800000, ResultId=2, Err=0.
REQ-032 Req=1111 held after reset, each lane dropping its Req after its own Done. Required: Done order lanes 0,1,2,3, with ExpStr low for at least 2 cycles between grants.
REQ-033 Ptr=2 (after serving lane 1), then Req=0011. Required: lane 0 granted first, then lane 1.
REQ-034 With the macro defined and TIMEOUT=255, ExpAck stuck at 0. Required: Done pulses after 255 RUN cycles with Err=1, Result=0x00000000; without the macro, Busy stays 1 and there is no Done.
REQ-035 ExpAck held at 1 for 5 cycles after DONE. Required: FSM stays in RELEASE for those 5 cycles; the next ExpStr rises only after ExpAck=0.
REQ-036 Reset pulled low mid-RUN. Required: ExpStr=0, Busy=0, Done=0 immediately; after release with Req=0001, lane 0 is served normally.
